// File: rtl/pattern_timer_pkg.sv
// Shared types and constants for the pattern-triggered delay timer.
// Provides the controller state enum, the start code and default timing.
package pattern_timer_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        SHIFT,
        COUNT,
        DONE
    } pt_state_t;

    localparam logic [3:0] PT_START_CODE = 4'b1101;

    localparam int PT_CYCLES_PER_UNIT = 1000;

endpackage

// File: rtl/start_code_detect.sv
// Overlapping start-code detector for the serial configuration stream.
// Ports: clk, clear (sync history wipe), enable (sample data), data, hit.
module start_code_detect
    import pattern_timer_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic enable,
    input  logic data,
    output logic hit
);

    // Last three sampled bits; a cleared history of zeros can never
    // complete a code, so a fresh code needs four new bits.
    logic [2:0] hist;

    always_ff @(posedge clk) begin
        if (clear) begin
            hist <= 3'b000;
        end else if (enable) begin
            hist <= {hist[1:0], data};
        end
    end

    // Combinational so the edge sampling the final bit acts on it.
    assign hit = enable && !clear
              && ({hist, data} == PT_START_CODE);

endmodule

// File: rtl/pattern_timer_ctrl.sv
// Pattern-triggered delay timer: find 1101, shift in a delay, count it out.
// Ports: clk, reset_n (sync, active-low), data, ack, shift_ena, counting,
// done, count; abort exists only when PATTERN_TIMER_ABORT_EN is defined.
module pattern_timer_ctrl
    import pattern_timer_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = PT_CYCLES_PER_UNIT,
    parameter int DELAY_W         = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data,
    input  logic               ack,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
`ifdef PATTERN_TIMER_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam int CW = $clog2(CYCLES_PER_UNIT);
    localparam int BW = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

    localparam logic [CW-1:0] CYC_LOAD = CW'(CYCLES_PER_UNIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DELAY_W - 1);

    pt_state_t     state;
    pt_state_t     state_next;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          abort_act;
    logic          det_clear;
    logic          hit;

`ifdef PATTERN_TIMER_ABORT_EN
    assign abort_act = abort && (state != SEARCH);
`else
    assign abort_act = 1'b0;
`endif

    // History is wiped on every path back into SEARCH.
    assign det_clear = !reset_n
                    || ((state == DONE) && ack)
                    || abort_act;

    start_code_detect u_detect (
        .clk    (clk),
        .clear  (det_clear),
        .enable (state == SEARCH),
        .data   (data),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_ena  = 1'b0;
        counting   = 1'b0;
        done       = 1'b0;
        case (state)
            SEARCH: begin
                if (hit) state_next = SHIFT;
            end
            SHIFT: begin
                shift_ena = 1'b1;
                if (bit_cnt == BIT_LAST) state_next = COUNT;
            end
            COUNT: begin
                counting = 1'b1;
                if (cyc_cnt == '0 && count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (ack) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
        if (abort_act) state_next = SEARCH;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            cyc_cnt <= '0;
            count   <= '0;
        end else if (abort_act) begin
            bit_cnt <= '0;
            cyc_cnt <= '0;
            count   <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    count   <= {count[DELAY_W-2:0], data};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) cyc_cnt <= CYC_LOAD;
                end
                COUNT: begin
                    // One whole unit elapses per full cycle-counter sweep.
                    if (cyc_cnt != '0) begin
                        cyc_cnt <= cyc_cnt - CW'(1);
                    end else if (count != '0) begin
                        count   <= count - DELAY_W'(1);
                        cyc_cnt <= CYC_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pattern_timer_ctrl.md
# pattern_timer_ctrl

Pattern-triggered delay timer controller. It watches a serial `data` stream for the start code 1101, then sequences three phases:
- capture a 4-bit delay value;
- count out (delay+1)×`CYCLES_PER_UNIT` clock cycles;
- assert `done` until the host acknowledges.

The block sits between the serial configuration input and the downstream timed-event logic. It owns the start-code detector and resets it for every new transaction.

## Interface
- `CYCLES_PER_UNIT`, default 1000: clock cycles per delay unit; legal range ≥ 2.
- `DELAY_W`, default 4: width of the delay field and of `count`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `data` in 1: serial input, sampled every rising edge in SEARCH and SHIFT only.
- `ack` in 1: host acknowledge, sampled only in DONE.
- `shift_ena` out 1: high while delay bits are being captured.
- `counting` out 1: high while the timer runs.
- `done` out 1: timer expired; held until `ack`.
- `count` out `DELAY_W`: delay register; in COUNT it shows the remaining whole units.
- `abort` in 1: present only with `PATTERN_TIMER_ABORT_EN`.

## Operation
- States: SEARCH, SHIFT, COUNT, DONE.
- **Reset** (`reset_n`=0 at an edge):
  - state becomes SEARCH; detector history is cleared;
  - bit counter, cycle counter and `count` become 0;
  - `shift_ena`, `counting` and `done` become 0.
  - Reset overrides every other event, in any state.
- **SEARCH**: the internal detector tracks the 1101 pattern with overlap (e.g. 11101 detects). The edge that samples the final 1 moves the state to SHIFT.
- **SHIFT**: lasts exactly `DELAY_W` cycles.
  - Each edge does `count` <= {`count`[DELAY_W-2:0], `data`}, so data arrives MSB first.
  - After the `DELAY_W`-th bit the state moves to COUNT.
  - The cycle counter is loaded with `CYCLES_PER_UNIT`-1.
- **COUNT**: the cycle counter decrements every cycle.
  - Counter at 0 and `count` > 0: decrement `count`; reload the cycle counter with `CYCLES_PER_UNIT`-1.
  - Counter at 0 and `count` = 0: go to DONE.
  - Total time in COUNT is exactly (delay+1)×`CYCLES_PER_UNIT` cycles.
- **DONE**: `done`=1 while waiting.
  - `ack`=1 at an edge moves the state to SEARCH and clears the detector history.
  - Bits seen before or during DONE never contribute to the next start code.
- `ack` outside DONE is ignored. `data` in COUNT and DONE is ignored.
- Outputs are Moore-decoded from the state register:
  - `shift_ena` = (state==SHIFT);
  - `counting` = (state==COUNT);
  - `done` = (state==DONE).
- Cycle counter width: $clog2(`CYCLES_PER_UNIT`). `count` is unsigned and never wraps, because decrement happens only when `count` > 0.

## Timing
- Edge E samples the final 1 of 1101. `shift_ena`=1 from after E through after E+`DELAY_W`-1, i.e. `DELAY_W` cycles.
- `counting` rises after edge E+`DELAY_W`. It stays high for (delay+1)×`CYCLES_PER_UNIT` cycles.
- `done` rises the cycle after `counting` falls.
- `ack` sampled at edge A: `done`=0 after A. The earliest new detection is at A+4; the start code must be sampled entirely at edges after A.
- `ack` held high through SEARCH has no effect.
- Delay=0 gives exactly `CYCLES_PER_UNIT` counting cycles.

## Configuration
- `PATTERN_TIMER_ABORT_EN` defined:
  - adds the `abort` input port;
  - `abort`=1 at an edge in SHIFT, COUNT or DONE forces SEARCH, clears the detector, sets `count`=0, and drops all status outputs after that edge;
  - `abort` in SEARCH is ignored;
  - `reset_n` takes priority over `abort`.
- Not defined: no `abort` port and no abort logic; behaviour is exactly as described above.

## Structure
- Shared package `pattern_timer_pkg`:
  - state enum `pt_state_t` (SEARCH, SHIFT, COUNT, DONE);
  - `PT_START_CODE` = 4'b1101;
  - default `CYCLES_PER_UNIT` constant.
- Sub-module `start_code_detect`: 1101 overlap detector with a synchronous `clear` input and a one-cycle `hit` pulse. It is instantiated once, and `clear` is driven high by reset, by `ack` in DONE, and by `abort`.

## Test plan
- **Reset mid-COUNT:** `reset_n`=0 for 1 cycle -> next cycle all outputs 0, `count`=0. A fresh 1101 is required to restart.
- **Nominal timing** (`CYCLES_PER_UNIT`=4): `data` 1,1,0,1 then delay bits 0,0,1,0 -> `shift_ena` high 4 cycles; `count`=2; `counting` high 12 cycles; `count` steps 2,1,0; then `done`=1. `ack` -> `done`=0 next cycle.
- **Overlap, zero delay:** `data` 1,1,1,0,1 then 0,0,0,0 -> detection on the 5th bit; `counting` high exactly 4 cycles.
- **Ignored inputs:** 1101 patterns fed during COUNT and DONE, plus `ack` pulses during COUNT -> no restart, no early `done`. After `ack`, the pattern suffix 1,0,1 alone does not detect.
- **Held `done`:** keep `ack` low for 50 cycles in DONE -> `done` stays 1 and `count` stays 0.
- **Abort** (`PATTERN_TIMER_ABORT_EN` defined): `abort` pulse in SHIFT after 2 bits -> SEARCH and `count`=0. Also check the same pulse in COUNT; then 1101 plus 0001 gives 8 counting cycles.
